// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding
// an LSB-first serialiser at a fixed baud rate.
module uart_tx_fifo #(
  parameter int CLK_HZ    = 36000000,
  parameter int BAUD      = 9600,
  parameter int FIFO_AW   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic       clk36m,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  input  logic       ovf_clr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       uart_tx
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW    = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [CW-1:0] TERM = CW'(DIV - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [2:0] SB_LAST = 3'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] N_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] N_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] P_ONE = FIFO_AW'(1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: bit period DIV must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_d;
  logic               wr_ok;
  logic               pop;

  state_t     state;
  state_t     state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [2:0] bit_idx;
  logic [2:0] bit_d;
  logic [7:0] shift;
  logic [7:0] shift_d;
  logic       tx_d;

  assign tx_full  = (count == N_FULL);
  assign tx_empty = (count == '0);
  assign wr_ok    = tx_wr & ~tx_full;

  always_comb begin
    count_d = count;
    unique case ({wr_ok, pop})
      2'b10:   count_d = count + N_ONE;
      2'b01:   count_d = count - N_ONE;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk36m) begin
    if (wr_ok) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk36m or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + P_ONE;
      if (pop)   rd_ptr <= rd_ptr + P_ONE;
      count <= count_d;
      // a dropped write outranks a clear on the same edge
      if (tx_wr && tx_full) tx_overflow <= 1'b1;
      else if (ovf_clr)     tx_overflow <= 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + C_ONE;
    bit_d   = bit_idx;
    shift_d = shift;
    tx_d    = uart_tx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!tx_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt == TERM) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt == TERM) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_idx + 3'd1;
            shift_d = {1'b0, shift[7:1]};
            tx_d    = shift[1];
          end
        end
      end
      STOP: begin
        if (cnt == TERM) begin
          cnt_d = '0;
          if (bit_idx != SB_LAST) begin
            bit_d = bit_idx + 3'd1;
          end else if (!tx_empty) begin
            // chain straight into the next start bit
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk36m or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
      uart_tx <= tx_d;
      tx_busy <= (state_d != IDLE) | (count_d != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: DIV=16 line timing,
// FIFO flags, overflow flag and reset abort.
module tb_uart_tx_fifo;

  logic       clk36m = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data, tx_data2;
  logic       tx_wr, tx_wr2;
  logic       ovf_clr, ovf_clr2;
  logic       tx_full, tx_empty, tx_busy;
  logic       tx_overflow, uart_tx;
  logic       tx_full2, tx_empty2, tx_busy2;
  logic       tx_overflow2, uart_tx2;

  int n_assert = 0;
  int n_fail   = 0;
  int since    = 0;

  always #5 clk36m = ~clk36m;

  uart_tx_fifo #(
    .CLK_HZ(160), .BAUD(10), .FIFO_AW(4), .STOP_BITS(1)
  ) u1 (
    .clk36m(clk36m), .reset_n(reset_n),
    .tx_data(tx_data), .tx_wr(tx_wr), .ovf_clr(ovf_clr),
    .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_busy(tx_busy), .tx_overflow(tx_overflow),
    .uart_tx(uart_tx)
  );

  uart_tx_fifo #(
    .CLK_HZ(160), .BAUD(10), .FIFO_AW(4), .STOP_BITS(2)
  ) u2 (
    .clk36m(clk36m), .reset_n(reset_n),
    .tx_data(tx_data2), .tx_wr(tx_wr2), .ovf_clr(ovf_clr2),
    .tx_full(tx_full2), .tx_empty(tx_empty2),
    .tx_busy(tx_busy2), .tx_overflow(tx_overflow2),
    .uart_tx(uart_tx2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk36m);
    since++;
  endtask

  // Entry: at the negedge inside cycle 'skip' of the frame.
  task automatic check_frame(input int which,
                             input logic [7:0] b,
                             input int sb,
                             input int skip,
                             input string tag);
    int bad;
    int n;
    logic exp;
    logic obs;
    logic [7:0] dec;
    bad = 0;
    dec = 8'h00;
    n = (9 + sb) * 16;
    for (int k = skip; k < n; k++) begin
      obs = (which == 2) ? uart_tx2 : uart_tx;
      if (k < 16)       exp = 1'b0;
      else if (k < 144) exp = b[(k - 16) / 16];
      else              exp = 1'b1;
      if (obs !== exp) bad++;
      if (k >= 16 && k < 144 && ((k - 16) % 16) == 8)
        dec[(k - 16) / 16] = obs;
      @(negedge clk36m);
    end
    chk({tag, "_badcycles"}, bad, 0);
    chk({tag, "_byte"}, dec, b);
  endtask

  initial begin
    reset_n = 1'b0;
    tx_data = 8'h00; tx_wr = 1'b0; ovf_clr = 1'b0;
    tx_data2 = 8'h00; tx_wr2 = 1'b0; ovf_clr2 = 1'b0;
    repeat (3) @(negedge clk36m);
    chk("rst_tx", uart_tx, 1);
    chk("rst_empty", tx_empty, 1);
    chk("rst_full", tx_full, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovf", tx_overflow, 0);
    chk("rst_tx2", uart_tx2, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk36m);
    chk("idle_tx", uart_tx, 1);

    // single byte 0x55
    tx_data = 8'h55; tx_wr = 1'b1;
    step;
    tx_wr = 1'b0;
    chk("n_tx_high", uart_tx, 1);
    chk("n_empty", tx_empty, 0);
    chk("n_busy", tx_busy, 1);
    step;
    chk("n1_empty", tx_empty, 1);
    chk("n1_busy", tx_busy, 1);
    check_frame(1, 8'h55, 1, 0, "f55");
    chk("post55_busy", tx_busy, 0);
    chk("post55_tx", uart_tx, 1);

    // LSB-first
    tx_data = 8'h01; tx_wr = 1'b1;
    step; tx_wr = 1'b0; step;
    check_frame(1, 8'h01, 1, 0, "f01");
    tx_data = 8'h80; tx_wr = 1'b1;
    step; tx_wr = 1'b0; step;
    check_frame(1, 8'h80, 1, 0, "f80");

    // back-to-back, with tx_data changed after queuing
    tx_data = 8'hA5; tx_wr = 1'b1;
    step;
    tx_data = 8'h3C;
    step;
    tx_wr = 1'b0; tx_data = 8'hFF;
    check_frame(1, 8'hA5, 1, 0, "fA5");
    check_frame(1, 8'h3C, 1, 0, "f3C");
    chk("b2b_busy", tx_busy, 0);

    // overflow with one byte in flight
    tx_data = 8'hEE; tx_wr = 1'b1;
    step; tx_wr = 1'b0; step;
    since = 0;
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'(i); tx_wr = 1'b1;
      step;
    end
    tx_wr = 1'b0;
    chk("ovf_full", tx_full, 1);
    chk("ovf_set", tx_overflow, 1);
    chk("ovf_notempty", tx_empty, 0);
    ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0;
    chk("ovf_clr", tx_overflow, 0);
    tx_data = 8'h77; tx_wr = 1'b1; ovf_clr = 1'b1;
    step;
    tx_wr = 1'b0; ovf_clr = 1'b0;
    chk("ovf_setwins", tx_overflow, 1);
    chk("ovf_stillfull", tx_full, 1);
    ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0;
    chk("ovf_clr2", tx_overflow, 0);
    check_frame(1, 8'hEE, 1, since, "fEE");
    chk("drain_notfull", tx_full, 0);
    for (int i = 0; i < 16; i++)
      check_frame(1, 8'(i), 1, 0, $sformatf("fq%0d", i));
    chk("drain_empty", tx_empty, 1);
    chk("drain_busy", tx_busy, 0);
    chk("drain_tx", uart_tx, 1);

    // two stop bits, next frame contiguous
    tx_data2 = 8'hFF; tx_wr2 = 1'b1;
    step;
    tx_data2 = 8'h00;
    step;
    tx_wr2 = 1'b0;
    check_frame(2, 8'hFF, 2, 0, "s2FF");
    check_frame(2, 8'h00, 2, 0, "s200");
    chk("s2_busy", tx_busy2, 0);

    // reset mid-frame
    tx_data = 8'h00; tx_wr = 1'b1;
    step;
    tx_data = 8'h11;
    step;
    tx_wr = 1'b0;
    repeat (20) step;
    chk("mid_low", uart_tx, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", uart_tx, 1);
    repeat (2) @(negedge clk36m);
    reset_n = 1'b1;
    step;
    chk("mid_empty", tx_empty, 1);
    chk("mid_busy", tx_busy, 0);
    repeat (40) step;
    chk("mid_idle_tx", uart_tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
